// File: rtl/tt_bin_clock_pkg.sv
// Encodings shared by the binary-clock controller, the hours/minutes/seconds datapath and the bench.
package tt_bin_clock_pkg;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_SEC  = 2'd1,
    FIELD_MIN  = 2'd2,
    FIELD_HOUR = 2'd3
  } field_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_IDLE = 2'd1,
    ST_ISSUE    = 2'd2,
    ST_HOLD     = 2'd3
  } state_e;

  // Button vectors are ordered {hour, minute, seconds}; seconds wins ties.
  function automatic field_e pick_field(input logic [2:0] rise);
    if (rise[0]) return FIELD_SEC;
    if (rise[1]) return FIELD_MIN;
    if (rise[2]) return FIELD_HOUR;
    return FIELD_NONE;
  endfunction

endpackage

// File: rtl/tt_bin_clock_ctrl_if.sv
// Set-command channel from the controller to the time counters (valid/ready).
interface tt_bin_clock_ctrl_if;
  import tt_bin_clock_pkg::*;

  logic   valid;
  field_e field;
  logic   dir;
  logic   ready;

  modport master (output valid, output field, output dir, input ready);
  modport slave  (input valid, input field, input dir, output ready);

endinterface

// File: rtl/tt_bin_clock_debounce.sv
// Synchroniser plus debouncer for one asynchronous pin: a new level is accepted
// only after DEBOUNCE_CYCLES consecutive synchronised samples agree on it.
module tt_bin_clock_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 3
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic pin_i,
  output logic level_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   sample;

  assign sample  = sync_q[SYNC_STAGES-1];
  assign level_o = level_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch, otherwise synthesis infers a latch.
    cnt_d   = '0;
    level_d = level_q;
    if (sample != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) level_d = sample;
      else                                       cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so each stage takes its neighbour's pre-edge value; blocking would collapse the chain.
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/tt_bin_clock_ctrl.sv
// Mode and set-sequence controller: 1 Hz prescaler in RUN, button-driven
// single-field inc/dec commands with auto-repeat in SET.
module tt_bin_clock_ctrl
  import tt_bin_clock_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 100,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned REPEAT_DELAY    = 50,
  parameter int unsigned REPEAT_RATE     = 20
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       time_set_i,
  input  logic                       id_switch_i,
  input  logic                       seconds_id_i,
  input  logic                       minute_id_i,
  input  logic                       hour_id_i,
  output logic                       tick_o,
  output logic                       running_o,
  tt_bin_clock_ctrl_if.master        cmd_if
);

  localparam int unsigned PRE_W   = $clog2(CLK_HZ);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

  logic [4:0] pins, lvl;
  logic       ts_lvl, dir_lvl, held;
  logic [2:0] btn, btn_rise, btn_prev_q;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_last;
  logic             first_q, first_d;
  field_e           field_q, field_d;
  logic             dir_q, dir_d;

  assign pins = {hour_id_i, minute_id_i, seconds_id_i, id_switch_i, time_set_i};

  for (genvar i = 0; i < 5; i++) begin : g_in
    tt_bin_clock_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i   (clk_i),
      .reset_ni(reset_ni),
      .pin_i   (pins[i]),
      .level_o (lvl[i])
    );
  end

  assign ts_lvl   = lvl[0];
  assign dir_lvl  = lvl[1];
  assign btn      = lvl[4:2];
  assign btn_rise = btn & ~btn_prev_q;

  // The accept cycle counts as repeat cycle 0, so HOLD starts at 1 and leaves on period-1.
  assign rpt_last = first_q ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_RATE - 1);

  always_comb begin
    held = 1'b0;
    case (field_q)
      FIELD_SEC:  held = btn[0];
      FIELD_MIN:  held = btn[1];
      FIELD_HOUR: held = btn[2];
      default:    held = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_RUN;
      pre_q      <= '0;
      rpt_q      <= '0;
      first_q    <= 1'b0;
      field_q    <= FIELD_NONE;
      dir_q      <= 1'b0;
      btn_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      rpt_q      <= rpt_d;
      first_q    <= first_d;
      field_q    <= field_d;
      dir_q      <= dir_d;
      btn_prev_q <= btn;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = '0;
    rpt_d   = '0;
    first_d = first_q;
    field_d = field_q;
    dir_d   = dir_q;
    case (state_q)
      ST_RUN: begin
        pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
        if (ts_lvl) state_d = ST_SET_IDLE;
      end
      ST_SET_IDLE: begin
        if (!ts_lvl) begin
          state_d = ST_RUN;
        end else if (|btn_rise) begin
          state_d = ST_ISSUE;
          field_d = pick_field(btn_rise);
          dir_d   = dir_lvl;
          first_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        rpt_d = RPT_W'(1);
        // A pending command always completes, even if SET mode was left meanwhile.
        if (cmd_if.ready) state_d = ts_lvl ? ST_HOLD : ST_RUN;
      end
      ST_HOLD: begin
        rpt_d = rpt_q + RPT_W'(1);
        if (!ts_lvl) begin
          state_d = ST_RUN;
        end else if (!held) begin
          state_d = ST_SET_IDLE;
        end else if (rpt_q == rpt_last) begin
          state_d = ST_ISSUE;
          first_d = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    running_o    = (state_q == ST_RUN);
    tick_o       = (state_q == ST_RUN) && (pre_q == PRE_LAST);
    cmd_if.valid = (state_q == ST_ISSUE);
    cmd_if.field = (state_q == ST_ISSUE) ? field_q : FIELD_NONE;
    cmd_if.dir   = (state_q == ST_ISSUE) && dir_q;
  end

endmodule

// File: tb/tb_tt_bin_clock_ctrl.sv
// Directed bench for tt_bin_clock_ctrl: table of button presses plus hand-written
// sequences for prescaler timing, stalled handshake, mode exit and mid-run reset.
module tb_tt_bin_clock_ctrl;
  import tt_bin_clock_pkg::*;

  localparam int LAT = 6;   // pin edge to cmd valid: sync 2 + debounce 3 + 1
  localparam int RD  = 50;  // first auto-repeat spacing
  localparam int RR  = 20;  // later auto-repeat spacing

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ts = 1'b0, id_sw = 1'b0, sec = 1'b0, mn = 1'b0, hr = 1'b0;
  logic tick, running;

  tt_bin_clock_ctrl_if cmd_if();

  tt_bin_clock_ctrl dut (
    .clk_i       (clk),
    .reset_ni    (rst_n),
    .time_set_i  (ts),
    .id_switch_i (id_sw),
    .seconds_id_i(sec),
    .minute_id_i (mn),
    .hour_id_i   (hr),
    .tick_o      (tick),
    .running_o   (running),
    .cmd_if      (cmd_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] btns;      // {hour, minute, seconds}
    logic       dir;
    int         len;       // cycles the pins are held high
    int         exp_n;     // commands expected
    field_e     exp_field;
  } vec_t;

  vec_t   vecs[8];
  int     n_checks = 0, n_err = 0, cyc = 0, c0 = 0;
  logic   v_prev = 1'b0, d_prev = 1'b0;
  field_e f_prev = FIELD_NONE;
  int     rise_q[$];
  field_e fld_q[$];
  logic   dirq_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and record/verify the command channel.
  task automatic step();
    logic r_edge;
    r_edge = cmd_if.ready;
    @(negedge clk);
    cyc++;
    if (v_prev && !r_edge) begin
      check("hold_valid", int'(cmd_if.valid), 1);
      check("hold_field", int'(cmd_if.field), int'(f_prev));
      check("hold_dir", int'(cmd_if.dir), int'(d_prev));
    end
    if (cmd_if.valid && !v_prev) begin
      rise_q.push_back(cyc);
      fld_q.push_back(cmd_if.field);
      dirq_q.push_back(cmd_if.dir);
    end
    if (tick || cmd_if.valid) check("tick_cmd_exclusive", int'(tick && cmd_if.valid), 0);
    v_prev = cmd_if.valid;
    f_prev = cmd_if.field;
    d_prev = cmd_if.dir;
  endtask

  task automatic clear_cmds();
    rise_q.delete();
    fld_q.delete();
    dirq_q.delete();
  endtask

  task automatic check_cmds(input string name, input int t0, input int exp_n,
                            input field_e f, input logic d);
    int exp_t;
    check({name, "_count"}, rise_q.size(), exp_n);
    for (int i = 0; i < rise_q.size() && i < exp_n; i++) begin
      exp_t = (i == 0) ? LAT : LAT + RD + RR * (i - 1);
      check({name, "_time"}, rise_q[i] - t0, exp_t);
      check({name, "_field"}, int'(fld_q[i]), int'(f));
      check({name, "_dir"}, int'(dirq_q[i]), int'(d));
    end
  endtask

  initial begin
    vecs[0] = '{"sec_inc",             3'b001, 1'b1,  10, 1, FIELD_SEC};
    vecs[1] = '{"min_dec_repeat",      3'b010, 1'b0, 120, 5, FIELD_MIN};
    vecs[2] = '{"hour_inc",            3'b100, 1'b1,  10, 1, FIELD_HOUR};
    vecs[3] = '{"glitch_2cyc",         3'b001, 1'b1,   2, 0, FIELD_SEC};
    vecs[4] = '{"pulse_3cyc",          3'b001, 1'b0,   3, 1, FIELD_SEC};
    vecs[5] = '{"sec_hour_same",       3'b101, 1'b1,  10, 1, FIELD_SEC};
    vecs[6] = '{"min_hour_same",       3'b110, 1'b0,  10, 1, FIELD_MIN};
    vecs[7] = '{"hour_dec_one_repeat", 3'b100, 1'b0,  60, 2, FIELD_HOUR};

    cmd_if.ready = 1'b1;

    // Reset values while reset is held.
    repeat (3) step();
    check("rst_tick", int'(tick), 0);
    check("rst_valid", int'(cmd_if.valid), 0);
    check("rst_field", int'(cmd_if.field), 0);
    check("rst_dir", int'(cmd_if.dir), 0);
    check("rst_running", int'(running), 1);

    // RUN: ticks after edges 99 and 199 following reset release.
    rst_n = 1'b1;
    for (int k = 1; k <= 250; k++) begin
      step();
      check("run_tick", int'(tick), int'(k == 99 || k == 199));
    end
    check("run_running", int'(running), 1);

    ts = 1'b1;
    repeat (10) step();
    check("set_mode_entered", int'(running), 0);

    foreach (vecs[i]) begin
      id_sw = vecs[i].dir;
      repeat (10) step();
      clear_cmds();
      c0 = cyc;
      {hr, mn, sec} = vecs[i].btns;
      repeat (vecs[i].len) step();
      {hr, mn, sec} = 3'b000;
      repeat (40) step();
      check_cmds(vecs[i].name, c0, vecs[i].exp_n, vecs[i].exp_field, vecs[i].dir);
    end

    // id_switch flipped while holding: repeats keep the latched direction.
    id_sw = 1'b1;
    repeat (10) step();
    clear_cmds();
    c0 = cyc;
    mn = 1'b1;
    repeat (20) step();
    id_sw = 1'b0;
    repeat (60) step();
    mn = 1'b0;
    repeat (40) step();
    check_cmds("dir_flip_in_hold", c0, 3, FIELD_MIN, 1'b1);

    // Seconds and hour together, then seconds released with hour still held.
    id_sw = 1'b1;
    repeat (10) step();
    clear_cmds();
    c0 = cyc;
    {hr, mn, sec} = 3'b101;
    repeat (10) step();
    sec = 1'b0;
    repeat (80) step();
    hr = 1'b0;
    repeat (40) step();
    check_cmds("sec_release_hour_held", c0, 1, FIELD_SEC, 1'b1);

    // Stalled handshake with time_set dropped during ISSUE.
    cmd_if.ready = 1'b0;
    repeat (10) step();
    clear_cmds();
    hr = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k >= LAT) begin
        check("stall_valid", int'(cmd_if.valid), 1);
        check("stall_field", int'(cmd_if.field), int'(FIELD_HOUR));
        check("stall_dir", int'(cmd_if.dir), 1);
      end
      if (k == 3) ts = 1'b0;
      if (k == 12) cmd_if.ready = 1'b1;
    end
    step();
    check("stall_valid_drop", int'(cmd_if.valid), 0);
    check("stall_back_to_run", int'(running), 1);
    check("stall_tick_k13", int'(tick), 0);
    for (int k = 14; k <= 120; k++) begin
      step();
      check("stall_run_tick", int'(tick), int'(k == 112));
    end
    check("stall_single_cmd", rise_q.size(), 1);
    hr = 1'b0;

    // Reset pulsed during HOLD with minute held.
    ts = 1'b1;
    repeat (10) step();
    check("t6_set_mode", int'(running), 0);
    clear_cmds();
    mn = 1'b1;
    repeat (20) step();
    check("t6_pre_cmd", rise_q.size(), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", int'(cmd_if.valid), 0);
    check("t6_rst_field", int'(cmd_if.field), 0);
    check("t6_rst_dir", int'(cmd_if.dir), 0);
    check("t6_rst_tick", int'(tick), 0);
    check("t6_rst_running", int'(running), 1);
    repeat (3) step();
    rst_n = 1'b1;
    clear_cmds();
    repeat (80) step();
    check("t6_no_cmd_held", rise_q.size(), 0);
    mn = 1'b0;
    repeat (20) step();
    clear_cmds();
    c0 = cyc;
    mn = 1'b1;
    repeat (10) step();
    mn = 1'b0;
    repeat (40) step();
    check_cmds("t6_repress", c0, 1, FIELD_MIN, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
